// File: rtl/reg_port_pkg.sv
// Shared types for the register-port arbiter between the I2C slave,
// the auxiliary requester and the Memory register file.
package reg_port_pkg;

   localparam int REG_ADDR_W = 6;
   localparam int REG_DATA_W = 8;

   typedef enum logic [1:0] {OWN_NONE, OWN_I2C, OWN_AUX} owner_e;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] wdata;
   } reg_acc_t;

endpackage

// File: rtl/reg_port_arbiter.sv
// Shares the Memory register port between the I2C slave (absolute priority)
// and one auxiliary req/gnt requester, routing read data back by owner tag.
module reg_port_arbiter
   import reg_port_pkg::*;
#(
   parameter logic [REG_ADDR_W-1:0] AUX_WR_BASE = 6'd8,
   parameter int                    MEM_RD_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] i2c_addr,
   input  logic [REG_DATA_W-1:0] i2c_wdata,
   input  logic                  i2c_write,
   input  logic                  i2c_read,
   output logic [REG_DATA_W-1:0] i2c_rdata,
   input  logic                  aux_req,
   input  logic                  aux_we,
   input  logic [REG_ADDR_W-1:0] aux_addr,
   input  logic [REG_DATA_W-1:0] aux_wdata,
   output logic                  aux_gnt,
   output logic                  aux_err,
   output logic                  aux_rvalid,
   output logic [REG_DATA_W-1:0] aux_rdata,
   output logic [REG_ADDR_W-1:0] mem_addr,
   output logic [REG_DATA_W-1:0] mem_wdata,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [REG_DATA_W-1:0] mem_rdata
);

   logic     i2c_strobe;
   logic     aux_elig;
   logic     aux_blocked;
   logic     acc_valid;
   logic     issue_write;
   logic     issue_read;
   reg_acc_t acc;
   owner_e   acc_owner;
   owner_e   rd_owner;
   owner_e   ret_owner;
   owner_e   tag_pipe [MEM_RD_LAT];

   assign i2c_strobe  = i2c_write | i2c_read;
   // The bubble after a grant gives the requester a cycle to drop aux_req.
   assign aux_elig    = aux_req & ~i2c_strobe & ~aux_gnt;
   assign aux_blocked = aux_elig & aux_we & (aux_addr < AUX_WR_BASE);

   always_comb begin
      acc       = '{we: i2c_write, addr: i2c_addr, wdata: i2c_wdata};
      acc_valid = i2c_strobe;
      acc_owner = i2c_strobe ? OWN_I2C : OWN_NONE;
      if (aux_elig) begin
         acc       = '{we: aux_we, addr: aux_addr, wdata: aux_wdata};
         acc_valid = 1'b1;
         acc_owner = OWN_AUX;
      end
   end

   assign issue_write = acc_valid & acc.we & ~aux_blocked;
   assign issue_read  = acc_valid & ~acc.we;

   // The oldest tag lines up with the cycle in which mem_rdata is valid.
   assign ret_owner  = tag_pipe[MEM_RD_LAT-1];
   assign aux_rvalid = (ret_owner == OWN_AUX);
   assign aux_rdata  = aux_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         aux_gnt   <= 1'b0;
         aux_err   <= 1'b0;
         rd_owner  <= OWN_NONE;
         i2c_rdata <= '0;
         for (int i = 0; i < MEM_RD_LAT; i++) tag_pipe[i] <= OWN_NONE;
      end else begin
         mem_write <= issue_write;
         mem_read  <= issue_read;
         if (issue_write | issue_read) begin
            mem_addr  <= acc.addr;
            mem_wdata <= acc.wdata;
         end
         aux_gnt  <= aux_elig;
         aux_err  <= aux_blocked;
         rd_owner <= issue_read ? acc_owner : OWN_NONE;
         tag_pipe[0] <= rd_owner;
         for (int i = 1; i < MEM_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
         if (ret_owner == OWN_I2C) i2c_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Drives two arbiters (read latency 1 and 2) with shared stimulus and checks
// them against a transaction-level model of the port-sharing rules.
module tb_reg_port_arbiter;
   import reg_port_pkg::*;

   localparam int N_CYC = 1500;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       preload;
   logic [5:0] i2c_addr;
   logic [7:0] i2c_wdata;
   logic       i2c_write, i2c_read;
   logic       aux_req, aux_we;
   logic [5:0] aux_addr;
   logic [7:0] aux_wdata;

   logic [7:0] i2c_rdata_1, i2c_rdata_2, aux_rdata_1, aux_rdata_2;
   logic [7:0] mem_wdata_1, mem_wdata_2, mem_rdata_1, mem_rdata_2;
   logic [5:0] mem_addr_1, mem_addr_2;
   logic       aux_gnt_1, aux_gnt_2, aux_err_1, aux_err_2;
   logic       aux_rvalid_1, aux_rvalid_2;
   logic       mem_write_1, mem_write_2, mem_read_1, mem_read_2;

   always #5 clk = ~clk;

   reg_port_arbiter #(.AUX_WR_BASE(6'd8), .MEM_RD_LAT(1)) dut_1 (
      .clk(clk), .rst_n(rst_n),
      .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_write(i2c_write),
      .i2c_read(i2c_read), .i2c_rdata(i2c_rdata_1),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt_1), .aux_err(aux_err_1), .aux_rvalid(aux_rvalid_1),
      .aux_rdata(aux_rdata_1),
      .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_write(mem_write_1),
      .mem_read(mem_read_1), .mem_rdata(mem_rdata_1)
   );

   reg_port_arbiter #(.AUX_WR_BASE(6'd8), .MEM_RD_LAT(2)) dut_2 (
      .clk(clk), .rst_n(rst_n),
      .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_write(i2c_write),
      .i2c_read(i2c_read), .i2c_rdata(i2c_rdata_2),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt_2), .aux_err(aux_err_2), .aux_rvalid(aux_rvalid_2),
      .aux_rdata(aux_rdata_2),
      .mem_addr(mem_addr_2), .mem_wdata(mem_wdata_2), .mem_write(mem_write_2),
      .mem_read(mem_read_2), .mem_rdata(mem_rdata_2)
   );

   function automatic logic [7:0] init_val(input int i);
      return (i == 5) ? 8'hA7 : 8'((i * 37 + 11) % 256);
   endfunction

   // Register-file models with 1- and 2-cycle read latency
   logic [7:0] mem_1 [64];
   logic [7:0] mem_2 [64];
   logic [7:0] rd_pipe_1;
   logic [7:0] rd_pipe_2 [2];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) begin
            mem_1[i] <= init_val(i);
            mem_2[i] <= init_val(i);
         end
      end else begin
         if (mem_write_1) mem_1[mem_addr_1] <= mem_wdata_1;
         if (mem_write_2) mem_2[mem_addr_2] <= mem_wdata_2;
      end
      rd_pipe_1    <= mem_1[mem_addr_1];
      rd_pipe_2[0] <= mem_2[mem_addr_2];
      rd_pipe_2[1] <= rd_pipe_2[0];
   end

   assign mem_rdata_1 = rd_pipe_1;
   assign mem_rdata_2 = rd_pipe_2[1];

   // Reference model: expected observations indexed by cycle number
   logic [7:0] ref_regs [64];
   bit         exp_gnt [N_CYC];
   bit         exp_err [N_CYC];
   bit         exp_wr [N_CYC];
   bit         exp_rd [N_CYC];
   logic [5:0] exp_addr [N_CYC];
   logic [7:0] exp_wdata [N_CYC];
   bit         exp_rv_1 [N_CYC];
   bit         exp_rv_2 [N_CYC];
   logic [7:0] exp_rdata_1 [N_CYC];
   logic [7:0] exp_rdata_2 [N_CYC];
   bit         i2c_upd_1 [N_CYC];
   bit         i2c_upd_2 [N_CYC];
   logic [7:0] i2c_val_1 [N_CYC];
   logic [7:0] i2c_val_2 [N_CYC];
   logic [7:0] held_1, held_2;
   int         cyc;
   bit         granted_last;
   bit         aux_pending;
   reg_acc_t   aux_cur;
   reg_acc_t   aux_q [$];
   int         errors = 0;
   int         checks = 0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, observed, expected);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N_CYC; i++) begin
         exp_gnt[i] = 0;   exp_err[i] = 0;   exp_wr[i] = 0;   exp_rd[i] = 0;
         exp_addr[i] = '0; exp_wdata[i] = '0;
         exp_rv_1[i] = 0;  exp_rv_2[i] = 0;
         exp_rdata_1[i] = '0; exp_rdata_2[i] = '0;
         i2c_upd_1[i] = 0; i2c_upd_2[i] = 0;
         i2c_val_1[i] = '0; i2c_val_2[i] = '0;
      end
      held_1 = '0;
      held_2 = '0;
      granted_last = 0;
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_gnt"}, int'(aux_gnt_1) + int'(aux_gnt_2), 0);
      checkOutput({tag, "_err"}, int'(aux_err_1) + int'(aux_err_2), 0);
      checkOutput({tag, "_rvalid"}, int'(aux_rvalid_1) + int'(aux_rvalid_2), 0);
      checkOutput({tag, "_aux_rdata"}, int'(aux_rdata_1) + int'(aux_rdata_2), 0);
      checkOutput({tag, "_i2c_rdata"}, int'(i2c_rdata_1) + int'(i2c_rdata_2), 0);
      checkOutput({tag, "_strobes"}, int'(mem_write_1) + int'(mem_read_1) +
                                     int'(mem_write_2) + int'(mem_read_2), 0);
      checkOutput({tag, "_mem_addr"}, int'(mem_addr_1) + int'(mem_addr_2), 0);
      checkOutput({tag, "_mem_wdata"}, int'(mem_wdata_1) + int'(mem_wdata_2), 0);
   endtask

   task automatic push_aux(input bit we, input logic [5:0] a, input logic [7:0] d);
      reg_acc_t t;
      t.we    = we;
      t.addr  = a;
      t.wdata = d;
      aux_q.push_back(t);
   endtask

   // Records what one issued access must look like on each latency variant
   task automatic model_issue(input bit we, input logic [5:0] a, input logic [7:0] d,
                              input owner_e own);
      logic [7:0] v;
      exp_addr[cyc+1] = a;
      if (we) begin
         exp_wr[cyc+1]    = 1;
         exp_wdata[cyc+1] = d;
         ref_regs[a]      = d;
      end else begin
         exp_rd[cyc+1] = 1;
         v = ref_regs[a];
         if (own == OWN_I2C) begin
            i2c_upd_1[cyc+3] = 1;  i2c_val_1[cyc+3] = v;
            i2c_upd_2[cyc+4] = 1;  i2c_val_2[cyc+4] = v;
         end else begin
            exp_rv_1[cyc+2] = 1;   exp_rdata_1[cyc+2] = v;
            exp_rv_2[cyc+3] = 1;   exp_rdata_2[cyc+3] = v;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (i2c_upd_1[cyc]) held_1 = i2c_val_1[cyc];
      if (i2c_upd_2[cyc]) held_2 = i2c_val_2[cyc];
      checkOutput("aux_gnt_1", int'(aux_gnt_1), int'(exp_gnt[cyc]));
      checkOutput("aux_gnt_2", int'(aux_gnt_2), int'(exp_gnt[cyc]));
      checkOutput("aux_err_1", int'(aux_err_1), int'(exp_err[cyc]));
      checkOutput("aux_err_2", int'(aux_err_2), int'(exp_err[cyc]));
      checkOutput("mem_write_1", int'(mem_write_1), int'(exp_wr[cyc]));
      checkOutput("mem_write_2", int'(mem_write_2), int'(exp_wr[cyc]));
      checkOutput("mem_read_1", int'(mem_read_1), int'(exp_rd[cyc]));
      checkOutput("mem_read_2", int'(mem_read_2), int'(exp_rd[cyc]));
      if (exp_wr[cyc] || exp_rd[cyc]) begin
         checkOutput("mem_addr_1", int'(mem_addr_1), int'(exp_addr[cyc]));
         checkOutput("mem_addr_2", int'(mem_addr_2), int'(exp_addr[cyc]));
      end
      if (exp_wr[cyc]) begin
         checkOutput("mem_wdata_1", int'(mem_wdata_1), int'(exp_wdata[cyc]));
         checkOutput("mem_wdata_2", int'(mem_wdata_2), int'(exp_wdata[cyc]));
      end
      checkOutput("aux_rvalid_1", int'(aux_rvalid_1), int'(exp_rv_1[cyc]));
      checkOutput("aux_rvalid_2", int'(aux_rvalid_2), int'(exp_rv_2[cyc]));
      checkOutput("aux_rdata_1", int'(aux_rdata_1), int'(exp_rdata_1[cyc]));
      checkOutput("aux_rdata_2", int'(aux_rdata_2), int'(exp_rdata_2[cyc]));
      checkOutput("i2c_rdata_1", int'(i2c_rdata_1), int'(held_1));
      checkOutput("i2c_rdata_2", int'(i2c_rdata_2), int'(held_2));
   endtask

   task automatic drive_and_decide(input bit w, input bit r, input logic [5:0] a,
                                   input logic [7:0] d);
      // The requester only lets go of a request once it has been granted
      if (exp_gnt[cyc] && aux_pending) begin
         checkOutput("aux_hold", int'(aux_gnt_1), 1);
         aux_pending = 0;
      end
      if (!aux_pending && aux_q.size() > 0) begin
         aux_cur     = aux_q.pop_front();
         aux_pending = 1;
      end
      aux_req   = aux_pending;
      aux_we    = aux_cur.we;
      aux_addr  = aux_cur.addr;
      aux_wdata = aux_cur.wdata;
      i2c_write = w;
      i2c_read  = r;
      i2c_addr  = a;
      i2c_wdata = d;
      if (w || r) begin
         granted_last = 0;
         model_issue(w, a, d, OWN_I2C);
      end else if (aux_pending && !granted_last) begin
         granted_last     = 1;
         exp_gnt[cyc+1]   = 1;
         if (aux_cur.we && aux_cur.addr < 6'd8) exp_err[cyc+1] = 1;
         else model_issue(aux_cur.we, aux_cur.addr, aux_cur.wdata, OWN_AUX);
      end else begin
         granted_last = 0;
      end
   endtask

   task automatic applyStimulus(input bit w, input bit r, input logic [5:0] a,
                                input logic [7:0] d);
      tick();
      drive_and_decide(w, r, a, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 6'd0, 8'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int gnt_count;
      bit prev_gnt;
      bit consec;
      int r;

      rst_n = 1'b0;
      preload = 1'b1;
      i2c_write = 0; i2c_read = 0; i2c_addr = '0; i2c_wdata = '0;
      aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
      aux_cur = '0;
      aux_pending = 0;
      cyc = 0;
      for (int i = 0; i < 64; i++) ref_regs[i] = init_val(i);
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      preload = 1'b0;
      rst_n = 1'b1;
      drive_and_decide(0, 0, 6'd0, 8'd0);

      $display("[TB] I2C read of preloaded reg 5");
      applyStimulus(0, 1, 6'd5, 8'd0);
      idle(4);
      checkOutput("i2c_read_a7_1", int'(i2c_rdata_1), 8'hA7);
      checkOutput("i2c_read_a7_2", int'(i2c_rdata_2), 8'hA7);

      $display("[TB] collision: aux read 3 against I2C write 9");
      push_aux(0, 6'd3, 8'd0);
      applyStimulus(1, 0, 6'd9, 8'h3C);
      idle(5);

      $display("[TB] protected aux write then allowed aux write");
      push_aux(1, 6'd2, 8'hFF);
      idle(4);
      applyStimulus(0, 1, 6'd2, 8'd0);
      idle(4);
      checkOutput("protected_reg2", int'(i2c_rdata_2), int'(init_val(2)));
      push_aux(1, 6'd8, 8'h5A);
      idle(4);
      applyStimulus(0, 1, 6'd8, 8'd0);
      idle(5);
      checkOutput("aux_write_lands", int'(i2c_rdata_2), 8'h5A);

      $display("[TB] interleaved I2C/aux reads");
      push_aux(0, 6'd11, 8'd0);
      applyStimulus(0, 1, 6'd10, 8'd0);
      idle(5);

      $display("[TB] sustained aux requests");
      for (int k = 0; k < 20; k++) push_aux(0, 6'(k + 16), 8'd0);
      gnt_count = 0;
      prev_gnt = 0;
      consec = 0;
      applyStimulus(0, 0, 6'd0, 8'd0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, 6'd0, 8'd0);
         if (aux_gnt_1) gnt_count++;
         if (aux_gnt_1 && prev_gnt) consec = 1;
         prev_gnt = aux_gnt_1;
      end
      checkOutput("sustained_grants", gnt_count, 5);
      checkOutput("no_consecutive_grants", int'(consec), 0);
      aux_q.delete();
      idle(6);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 300; n++) begin
         if (aux_q.size() == 0 && $urandom_range(0, 2) == 0)
            push_aux(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
         r = $urandom_range(0, 9);
         applyStimulus(r < 2, r == 1 || r == 2, 6'($urandom_range(0, 63)), 8'($urandom));
      end
      aux_q.delete();
      idle(6);

      $display("[TB] reset while an aux read is in flight");
      push_aux(0, 6'd3, 8'd0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 6'd0, 8'd0);
         if (exp_gnt[cyc]) break;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      clear_model();
      aux_pending = 1;
      aux_cur.we = 0;
      aux_cur.addr = 6'd3;
      aux_req = 1;
      aux_we = 0;
      aux_addr = 6'd3;
      repeat (2) @(posedge clk);
      #1;
      cyc += 2;
      rst_n = 1'b1;
      drive_and_decide(0, 0, 6'd0, 8'd0);
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
